// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32 controller.
// States, opcodes, ALU codes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] r;
        r = IMM_I;
        case (op)
            OP_SW:   r = IMM_S;
            OP_BEQ:  r = IMM_B;
            OP_JAL:  r = IMM_J;
            default: r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and instruction fields.
// legal flags funct3 values the datapath ALU can execute.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] ALUControl,
    output logic       legal
);

    logic [2:0] func_ctl;

    always_comb begin
        func_ctl = ALU_ADD;
        legal    = 1'b1;
        case (funct3)
            3'b000:  func_ctl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  func_ctl = ALU_SLT;
            3'b110:  func_ctl = ALU_OR;
            3'b111:  func_ctl = ALU_AND;
            default: legal    = 1'b0;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB:  ALUControl = ALU_SUB;
            ALUOP_FUNC: ALUControl = func_ctl;
            default:    ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the shared multicycle RV32 datapath, with
// retire counter and sticky illegal-instruction halt.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    state_t     state_next;
    state_t     dec_next;
    logic [1:0] alu_op;
    logic       func_legal;
    logic       pc_update;
    logic       branch;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic       retire;

    alu_decoder u_alu_dec (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl),
        .legal      (func_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        dec_next = ILLEGAL;
        case (op)
            OP_LW, OP_SW: if (funct3 == 3'b010) dec_next = MEMADR;
            OP_R:         if (func_legal) dec_next = EXECR;
            OP_I:         if (func_legal) dec_next = EXECI;
            OP_BEQ:       if (funct3 == 3'b000) dec_next = BEQ;
            OP_JAL:       dec_next = JAL;
            default:      dec_next = ILLEGAL;
        endcase
    end

    always_comb begin
        state_next = state;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        case (state)
            FETCH: begin
                ir_we      = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURES;
                pc_update  = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                state_next = dec_next;
            end
            MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = RES_RDATA;
                reg_we     = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_we     = 1'b1;
                state_next = FETCH;
            end
            EXECR: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_FUNC;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNC;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_we     = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = ALUWB;
            end
            ILLEGAL:  state_next = ILLEGAL;
            default:  state_next = FETCH;
        endcase
    end

    // Enables are masked by reset itself so nothing fires while it is held.
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_we;
    assign MemWrite = ~reset & mem_we;
    assign RegWrite = ~reset & reg_we;
    assign ImmSrc   = imm_src(op);

    assign retire = (state == MEMWB) || (state == MEMWRITE) ||
                    (state == ALUWB) || (state == BEQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      illegal <= 1'b0;
        else if (state_next == ILLEGAL) illegal <= 1'b1;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected
// control words are queued by stimulus and checked by a monitor.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       regw;
        logic       ill;
    } ctl_t;

    typedef struct {
        string      tag;
        ctl_t       e;
        ctl_t       m;
        logic [3:0] ret;
    } ent_t;

    localparam int K_LW  = 0;
    localparam int K_SW  = 1;
    localparam int K_R   = 2;
    localparam int K_I   = 3;
    localparam int K_BEQ = 4;
    localparam int K_JAL = 5;
    localparam int K_ILL = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal;
    logic [3:0] retired;

    int         tests = 0;
    int         fails = 0;
    ent_t       q[$];
    logic [3:0] exp_ret = '0;
    logic [1:0] cur_imm = '0;
    logic       cur_imm_care = 1'b0;

    multicycle_controller #(.CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic ctl_t c(
        input logic pcw, input logic adr, input logic memw,
        input logic irw, input logic [1:0] res, input logic [1:0] sa,
        input logic [1:0] sb, input logic [2:0] alu,
        input logic regw, input logic ill
    );
        ctl_t r;
        r = '{pcw, adr, memw, irw, res, sa, sb, alu, 2'b00, regw, ill};
        return r;
    endfunction

    // Enables and illegal are always checked; mux fields only when listed.
    function automatic ctl_t mk(
        input logic adr, input logic res, input logic sa,
        input logic sb, input logic alu
    );
        ctl_t r;
        r      = '0;
        r.pcw  = 1'b1;
        r.memw = 1'b1;
        r.irw  = 1'b1;
        r.regw = 1'b1;
        r.ill  = 1'b1;
        r.adr  = adr;
        r.res  = {2{res}};
        r.sa   = {2{sa}};
        r.sb   = {2{sb}};
        r.alu  = {3{alu}};
        return r;
    endfunction

    task automatic chk_ctl(input string tag, input ctl_t a,
                           input ctl_t e, input ctl_t m);
        tests++;
        if (((a ^ e) & m) != '0) begin
            fails++;
            $display("FAIL %s ctl: got %h want %h mask %h", tag, a, e, m);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] a,
                           input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", tag, a, e);
        end
    endtask

    task automatic push(input string tag, input ctl_t e, input ctl_t m);
        ent_t t;
        t.tag   = tag;
        t.e     = e;
        t.m     = m;
        t.e.imm = cur_imm;
        t.m.imm = cur_imm_care ? 2'b11 : 2'b00;
        t.ret   = exp_ret;
        q.push_back(t);
    endtask

    initial begin : monitor
        ent_t t;
        ctl_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                t = q.pop_front();
                a = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite,
                     illegal};
                chk_ctl(t.tag, a, t.e, t.m);
                chk_val({t.tag, " retired"}, 32'(retired), 32'(t.ret));
            end
        end
    end

    task automatic do_reset(input string tag);
        reset        = 1'b1;
        exp_ret      = '0;
        cur_imm_care = 1'b0;
        push(tag, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Called #1 after a posedge with the DUT in FETCH.
    task automatic do_instr(
        input string tag, input logic [6:0] o, input logic [2:0] f,
        input logic b5, input logic z, input logic [2:0] fa,
        input int kind, input logic [1:0] imm, input logic care
    );
        int n;
        op           = o;
        funct3       = f;
        funct7b5     = b5;
        Zero         = z;
        cur_imm      = imm;
        cur_imm_care = care;
        n            = 2;
        push({tag, "/F"}, c(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0),
             mk(1, 1, 1, 1, 1));
        push({tag, "/D"}, c(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 0, 0),
             mk(0, 0, 1, 1, 1));
        case (kind)
            K_LW: begin
                push({tag, "/MA"}, c(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 0, 0),
                     mk(0, 0, 1, 1, 1));
                push({tag, "/MR"}, c(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0),
                     mk(1, 1, 0, 0, 0));
                push({tag, "/MWB"}, c(0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0),
                     mk(0, 1, 0, 0, 0));
                n = 5;
            end
            K_SW: begin
                push({tag, "/MA"}, c(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 0, 0),
                     mk(0, 0, 1, 1, 1));
                push({tag, "/MW"}, c(0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0),
                     mk(1, 1, 0, 0, 0));
                n = 4;
            end
            K_R, K_I: begin
                push({tag, "/EX"},
                     c(0, 0, 0, 0, 0, 2'b10, (kind == K_R) ? 2'b00 : 2'b01,
                       fa, 0, 0),
                     mk(0, 0, 1, 1, 1));
                push({tag, "/WB"}, c(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0),
                     mk(0, 1, 0, 0, 0));
                n = 4;
            end
            K_BEQ: begin
                push({tag, "/BEQ"}, c(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0),
                     mk(0, 1, 1, 1, 1));
                n = 3;
            end
            K_JAL: begin
                push({tag, "/JAL"}, c(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0),
                     mk(0, 1, 1, 1, 1));
                push({tag, "/WB"}, c(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0),
                     mk(0, 1, 0, 0, 0));
                n = 4;
            end
            default: n = 2;
        endcase
        repeat (n) @(posedge clk);
        #1;
        if (kind != K_ILL) exp_ret = exp_ret + 4'd1;
    endtask

    task automatic hold_illegal(input string tag, input int n);
        repeat (n)
            push(tag, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0));
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        reset    = 1'b1;
        op       = '0;
        funct3   = '0;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        @(posedge clk);
        #1;
        do_reset("rst0");

        do_instr("lw",    7'b0000011, 3'b010, 0, 0, 3'b000, K_LW,  2'b00, 1);
        do_instr("sw",    7'b0100011, 3'b010, 0, 0, 3'b000, K_SW,  2'b01, 1);
        do_instr("sub",   7'b0110011, 3'b000, 1, 0, 3'b001, K_R,   2'b00, 0);
        do_instr("add",   7'b0110011, 3'b000, 0, 0, 3'b000, K_R,   2'b00, 0);
        do_instr("slt",   7'b0110011, 3'b010, 0, 0, 3'b101, K_R,   2'b00, 0);
        do_instr("or",    7'b0110011, 3'b110, 0, 0, 3'b011, K_R,   2'b00, 0);
        do_instr("and",   7'b0110011, 3'b111, 0, 0, 3'b010, K_R,   2'b00, 0);
        do_instr("addi",  7'b0010011, 3'b000, 1, 0, 3'b000, K_I,   2'b00, 1);
        do_instr("ori",   7'b0010011, 3'b110, 0, 0, 3'b011, K_I,   2'b00, 1);
        do_instr("beq_t", 7'b1100011, 3'b000, 0, 1, 3'b000, K_BEQ, 2'b10, 1);
        do_instr("beq_n", 7'b1100011, 3'b000, 0, 0, 3'b000, K_BEQ, 2'b10, 1);
        do_instr("jal",   7'b1101111, 3'b011, 0, 0, 3'b000, K_JAL, 2'b11, 1);

        do_instr("ill_op", 7'b1110011, 3'b000, 0, 0, 3'b000, K_ILL, 2'b00, 1);
        hold_illegal("ill_op/HALT", 100);
        do_reset("rst1");

        do_instr("ill_beq", 7'b1100011, 3'b001, 0, 0, 3'b000, K_ILL, 2'b10, 1);
        hold_illegal("ill_beq/HALT", 3);
        do_reset("rst2");

        do_instr("ill_lw", 7'b0000011, 3'b000, 0, 0, 3'b000, K_ILL, 2'b00, 1);
        hold_illegal("ill_lw/HALT", 3);
        do_reset("rst3");

        do_instr("add1", 7'b0110011, 3'b000, 0, 0, 3'b000, K_R, 2'b00, 0);

        // Reset lands between edges while MemWrite is high.
        op           = 7'b0100011;
        funct3       = 3'b010;
        cur_imm      = 2'b01;
        cur_imm_care = 1'b1;
        push("swr/F", c(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0),
             mk(1, 1, 1, 1, 1));
        push("swr/D", c(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 0, 0),
             mk(0, 0, 1, 1, 1));
        push("swr/MA", c(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 0, 0),
             mk(0, 0, 1, 1, 1));
        push("swr/MW", c(0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0),
             mk(1, 1, 0, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_val("midrst MemWrite", 32'(MemWrite), 32'd0);
        chk_val("midrst retired", 32'(retired), 32'd0);
        chk_val("midrst PCWrite", 32'(PCWrite), 32'd0);
        @(posedge clk);
        #1;
        do_reset("rst4");

        for (int i = 0; i < 16; i++)
            do_instr("beq_w", 7'b1100011, 3'b000, 0, 1'(i), 3'b000,
                     K_BEQ, 2'b10, 1);
        chk_val("wrap retired", 32'(retired), 32'd0);
        do_instr("lw_w", 7'b0000011, 3'b010, 0, 0, 3'b000, K_LW, 2'b00, 1);
        chk_val("post-wrap retired", 32'(retired), 32'd1);

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
